// File: rtl/alu_pkg.sv
// Shared ALU definitions: result/opcode widths, opcode encodings and the illegal-op test.
package alu_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_AND = 3'd3;
  localparam logic [OP_W-1:0] OP_OR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR = 3'd5;

  // Everything above the last defined opcode is unimplemented in the ALU.
  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return op > OP_XOR;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Capture FIFO behind the ALU: stores {opcode, result} with push-time flags and releases
// entries over valid/ready, counting pushes rejected while full.
module alu_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_opcode,
  input  logic [DATA_W-1:0]        in_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_W-1:0]          out_opcode,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);
  import alu_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = OP_W + DATA_W + 3;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic          push, pop;
  logic [EW-1:0] wr_entry, head;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Entry layout, LSB first: result, opcode, zero, neg, illegal.
  assign wr_entry = {is_illegal_op(in_opcode), in_result[DATA_W-1],
                     (in_result == '0), in_opcode, in_result};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (in_valid && !in_ready && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      if (push) mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Outputs come straight off the storage registers; nothing from in_* reaches them.
  assign head        = mem_q[rd_ptr_q];
  assign out_result  = head[DATA_W-1:0];
  assign out_opcode  = head[DATA_W +: OP_W];
  assign out_zero    = head[DATA_W+OP_W];
  assign out_neg     = head[DATA_W+OP_W+1];
  assign out_illegal = head[DATA_W+OP_W+2];
  assign count       = count_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed vector table, hand sequences and random traffic
// checked each cycle against a queue model of the FIFO.
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [2:0] in_opcode, out_opcode;
  logic [7:0] in_result, out_result;
  logic       out_zero, out_neg, out_illegal;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] res;
  } ent_t;

  ent_t q[$];
  int   m_drops = 0;

  typedef struct {
    bit         iv;
    logic [2:0] op;
    logic [7:0] res;
    bit         ordy;
    int         e_cnt;
    int         e_op;
    int         e_res;
    int         e_drop;
  } vec_t;

  vec_t tbl[10];

  alu_result_fifo #(.DEPTH(4), .DATA_W(8), .OP_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_result(out_result), .out_zero(out_zero), .out_neg(out_neg),
    .out_illegal(out_illegal), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Compare every visible output against the model's current state.
  task automatic check_model();
    chk("count", int'(count), q.size());
    chk("in_ready", int'(in_ready), int'(q.size() < 4));
    chk("out_valid", int'(out_valid), int'(q.size() > 0));
    chk("drop_cnt", int'(drop_cnt), m_drops);
    if (q.size() > 0) begin
      chk("head_op", int'(out_opcode), int'(q[0].op));
      chk("head_res", int'(out_result), int'(q[0].res));
      chk("head_zero", int'(out_zero), int'(q[0].res == 8'd0));
      chk("head_neg", int'(out_neg), int'(q[0].res >= 8'd128));
      chk("head_illegal", int'(out_illegal), int'(q[0].op >= 3'd6));
    end
  endtask

  // Called at a negedge: drive, check pre-edge state, clock, advance the model.
  task automatic step(input bit iv, input logic [2:0] op, input logic [7:0] res, input bit ordy);
    bit do_push, do_pop;
    ent_t e;
    in_valid  = iv;
    in_opcode = op;
    in_result = res;
    out_ready = ordy;
    check_model();
    do_push = iv && (q.size() < 4);
    do_pop  = ordy && (q.size() > 0);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.op = op; e.res = res;
      q.push_back(e);
    end
    if (iv && !do_push && m_drops < 255) m_drops++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_opcode = 0; in_result = 0; out_ready = 0;
    // Expectations are the state right after each row's clock edge.
    tbl[0] = '{1, 3'd0, 8'h04, 0, 1, 0, 8'h04, 0};
    tbl[1] = '{1, 3'd1, 8'hFE, 0, 2, 0, 8'h04, 0};
    tbl[2] = '{0, 3'd0, 8'h00, 1, 1, 1, 8'hFE, 0};
    tbl[3] = '{0, 3'd0, 8'h00, 1, 0, -1, -1, 0};
    tbl[4] = '{1, 3'd3, 8'h01, 0, 1, 3, 8'h01, 0};
    tbl[5] = '{1, 3'd4, 8'h03, 0, 2, 3, 8'h01, 0};
    tbl[6] = '{1, 3'd5, 8'h02, 0, 3, 3, 8'h01, 0};
    tbl[7] = '{1, 3'd2, 8'h18, 0, 4, 3, 8'h01, 0};
    tbl[8] = '{1, 3'd0, 8'h55, 0, 4, 3, 8'h01, 1};
    tbl[9] = '{0, 3'd0, 8'h00, 1, 3, 4, 8'h03, 1};

    repeat (2) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_result", int'(out_result), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].iv, tbl[i].op, tbl[i].res, tbl[i].ordy);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_drop", i), int'(drop_cnt), tbl[i].e_drop);
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].e_cnt != 4));
      if (tbl[i].e_cnt > 0) begin
        chk($sformatf("tbl%0d_head_op", i), int'(out_opcode), tbl[i].e_op);
        chk($sformatf("tbl%0d_head_res", i), int'(out_result), tbl[i].e_res);
      end
    end

    // Simultaneous push/pop at count 3 across pointer wrap.
    for (int i = 0; i < 6; i++) begin
      step(1, 3'($urandom_range(5)), 8'($urandom), 1);
      chk("pp_count", int'(count), 3);
    end

    // Illegal op with zero result is stored and delivered.
    for (int i = 0; i < 4 && q.size() > 0; i++) step(0, 3'd0, 8'd0, 1);
    step(1, 3'd6, 8'h00, 0);
    chk("ill_valid", int'(out_valid), 1);
    chk("ill_flag", int'(out_illegal), 1);
    chk("ill_zero", int'(out_zero), 1);
    step(0, 3'd0, 8'd0, 1);
    chk("ill_drained", int'(count), 0);

    // Saturate drop counter at full.
    for (int i = 0; i < 304; i++) step(1, 3'($urandom_range(7)), 8'($urandom), 0);
    chk("drop_sat", int'(drop_cnt), 255);

    // Asynchronous reset mid-stream off a clock edge.
    for (int i = 0; i < 2; i++) step(0, 3'd0, 8'd0, 1);
    chk("pre_rst_count", int'(count), 2);
    in_valid = 1; in_opcode = 3'd2; in_result = 8'h33; out_ready = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_op", int'(out_opcode), 0);
    chk("arst_out_res", int'(out_result), 0);
    chk("arst_drop", int'(drop_cnt), 0);
    q.delete();
    m_drops = 0;
    in_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(3) != 0), 3'($urandom_range(7)),
           8'($urandom), bit'($urandom_range(1)));
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
